// File: rtl/data_types_pkg.sv
// Shared types for the UART blocks: line configuration, receiver states and
// the oversampling constants used by the receiver.
package data_types_pkg;

  // Width of the baud divider carried in the shared configuration word.
  localparam int CFG_DIV_W = 16;

  // Oversample ticks per bit; the receiver's phase logic assumes 16.
  localparam int OS_RATE = 16;
  localparam int SC_W    = $clog2(OS_RATE);

  // Line configuration shared by transmitter and receiver.
  typedef struct packed {
    logic [CFG_DIV_W-1:0] br_div;  // transmitter baud divider
    logic                 word;    // 1 = 9 data bits, 0 = 8
    logic                 stop;    // 1 = 2 stop bits, 0 = 1
  } config_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Two-out-of-three vote used when mid-bit majority sampling is built in.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_os_tick_gen.sv
// Oversample tick generator: counts clk cycles 0..div and emits a one-cycle
// tick when the count equals div. Held at zero while clr is high so that the
// first tick of a frame always lands div+1 cycles after the start edge.
module os_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = !clr && (cnt == div);

  // Free-running divider; wraps on reaching div (>= guards a div lowered mid-count).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || (cnt >= div)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 8 or 9 data bits LSB first, 1 or 2 stop
// bits, one-cycle valid pulse with a framing-error flag.
// Build option: define UART_RX_MAJORITY_EN to take each bit as the majority
// of samples 7, 8 and 9 (decision at 9) instead of a single sample at 7.
module uart_rx
  import data_types_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_in,
  input  logic             enable,
  input  config_t          rx_cfg,
  input  logic [DIV_W-1:0] os_div,
  output logic [8:0]       data,
  output logic             valid,
  output logic             frame_err,
  output logic             busy
);

  rx_state_t       state;
  logic            sync1;
  logic            rx_s;
  logic            rx_prev;
  logic            start_edge;
  logic            tick;
  logic [SC_W-1:0] sc;
  logic [3:0]      bit_idx;
  logic [8:0]      shift;
  logic            word9;
  logic            stop2;
  logic            stop_idx;
  logic            err;
  logic            bit_val;
  logic            decide;
  logic            unused_cfg;

  // The baud divider field belongs to the transmitter.
  assign unused_cfg = ^rx_cfg.br_div;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  // NOTE: these reset to 1 (idle line) so that releasing reset is never
  // mistaken for a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx_in;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  // A line that stays low produces no new edge, so a break cannot retrigger.
  assign start_edge = rx_prev && !rx_s;

  os_tick_gen #(
    .DIV_W(DIV_W)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state == RX_IDLE),
    .div  (os_div),
    .tick (tick)
  );

`ifdef UART_RX_MAJORITY_EN
  localparam logic [SC_W-1:0] DECIDE_CNT = SC_W'(9);

  logic v7;
  logic v8;

  // Capture the two early mid-bit samples; the third is rx_s at the decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v7 <= 1'b0;
      v8 <= 1'b0;
    end else if (tick) begin
      if (sc == SC_W'(7)) v7 <= rx_s;
      if (sc == SC_W'(8)) v8 <= rx_s;
    end
  end

  assign bit_val = majority3(v7, v8, rx_s);
`else
  localparam logic [SC_W-1:0] DECIDE_CNT = SC_W'(7);

  assign bit_val = rx_s;
`endif

  assign decide = tick && (sc == DECIDE_CNT);
  assign busy   = (state != RX_IDLE);

  // Frame FSM. The sample counter is not cleared between bits: it runs on
  // from the start-bit decision so every later bit is decided at the same
  // phase, exactly OS_RATE ticks after the previous one.
  // NOTE: all state here uses non-blocking assignments so every branch sees
  // the pre-edge values of sc, bit_idx and err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RX_IDLE;
      sc        <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      word9     <= 1'b0;
      stop2     <= 1'b0;
      stop_idx  <= 1'b0;
      err       <= 1'b0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // NOTE: valid defaults low each cycle so it can only ever be a pulse.
      valid <= 1'b0;
      unique case (state)
        RX_IDLE: begin
          sc <= '0;
          if (enable && start_edge) begin
            word9    <= rx_cfg.word;
            stop2    <= rx_cfg.stop;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            err      <= 1'b0;
            shift    <= '0;
            state    <= RX_START;
          end
        end

        RX_START: begin
          if (tick) begin
            sc <= sc + SC_W'(1);
            if (decide) begin
              if (bit_val) begin
                state <= RX_IDLE;  // false start: line was high at mid-bit
              end else begin
                bit_idx <= '0;
                state   <= RX_DATA;
              end
            end
          end
        end

        RX_DATA: begin
          if (tick) begin
            sc <= sc + SC_W'(1);
            if (decide) begin
              shift[bit_idx] <= bit_val;
              bit_idx        <= bit_idx + 4'd1;
              if (bit_idx == (word9 ? 4'd8 : 4'd7)) begin
                state <= RX_STOP;
              end
            end
          end
        end

        RX_STOP: begin
          if (tick) begin
            sc <= sc + SC_W'(1);
            if (decide) begin
              if (stop_idx == stop2) begin
                // Deliver at mid stop bit so a back-to-back start edge is seen.
                data      <= word9 ? shift : {1'b0, shift[7:0]};
                frame_err <= err || !bit_val;
                valid     <= 1'b1;
                state     <= RX_IDLE;
              end else begin
                err      <= err || !bit_val;
                stop_idx <= 1'b1;
              end
            end
          end
        end

        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames, glitches, break, reset
// and enable cases, then randomized frames checked against a frame-level
// model (expected word and framing error computed from the bits sent).
module tb_uart_rx;
  import data_types_pkg::*;

  typedef struct {
    logic [8:0] d;
    logic       e;
    logic       b;
  } rec_t;

  logic        clk;
  logic        rst_n;
  logic        rx_in;
  logic        enable;
  config_t     rx_cfg;
  logic [15:0] os_div;
  logic [8:0]  data;
  logic        valid;
  logic        frame_err;
  logic        busy;

  int   n_checks;
  int   n_fail;
  rec_t exp_q[$];
  rec_t got_q[$];
  bit   busy_seen;
  bit   prev_valid;
  int   long_pulses;

  uart_rx #(.DIV_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_in    (rx_in),
    .enable   (enable),
    .rx_cfg   (rx_cfg),
    .os_div   (os_div),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: record every delivered word away from the active edge.
  always @(negedge clk) begin
    if (busy) busy_seen = 1'b1;
    if (valid) begin
      got_q.push_back('{d: data, e: frame_err, b: busy});
      if (prev_valid) long_pulses++;
    end
    prev_valid = valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame-level model: what a correct receiver must report for a frame.
  task automatic exp_push(input logic [8:0] w, input bit nine, input bit two,
                          input bit s1, input bit s2);
    rec_t r;
    r.d = nine ? w : {1'b0, w[7:0]};
    r.e = !s1 || (two && !s2);
    r.b = 1'b0;
    exp_q.push_back(r);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_in = 1'b1;
    end
  endtask

  // Drive one frame, one level per clk. glitch = cycle index to invert (-1
  // none), cut = stop driving after that many cycles (-1 full frame).
  task automatic send_frame(input logic [8:0] w, input bit nine, input bit two,
                            input bit s1, input bit s2, input int glitch,
                            input int cut, input bit expect_it);
    int   bitlen;
    int   nbits;
    int   total;
    logic lv[12];
    bitlen = 16 * (int'(os_div) + 1);
    nbits  = nine ? 9 : 8;
    for (int i = 0; i < 12; i++) lv[i] = 1'b1;
    lv[0] = 1'b0;
    for (int i = 0; i < nbits; i++) lv[1+i] = w[i];
    lv[1+nbits] = s1;
    lv[2+nbits] = s2;
    total = (1 + nbits + (two ? 2 : 1)) * bitlen;
    if (cut >= 0 && cut < total) total = cut;
    rx_cfg.word = nine;
    rx_cfg.stop = two;
    if (expect_it) exp_push(w, nine, two, s1, s2);
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      rx_in = lv[c/bitlen] ^ (c == glitch);
      if (c == 2 * bitlen) begin
        // Configuration changes mid-frame must not affect this frame.
        rx_cfg.word = ~nine;
        rx_cfg.stop = ~two;
      end
    end
  endtask

  // Wait (bounded) for every expected word, then compare in order.
  task automatic drain(input string tag, input int budget);
    int   waited;
    rec_t g;
    rec_t e;
    waited = 0;
    while (got_q.size() < exp_q.size() && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    repeat (4) @(negedge clk);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check({tag, "_data"}, g.d, e.d);
      check({tag, "_ferr"}, g.e, e.e);
      check({tag, "_busy_at_valid"}, g.b, e.b);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    int base;
    n_checks    = 0;
    n_fail      = 0;
    busy_seen   = 1'b0;
    prev_valid  = 1'b0;
    long_pulses = 0;
    rst_n       = 1'b0;
    rx_in       = 1'b1;
    enable      = 1'b1;
    rx_cfg      = '0;
    os_div      = 16'd3;
    repeat (3) @(negedge clk);
    check("reset_data", data, 9'h000);
    check("reset_valid", valid, 1'b0);
    check("reset_ferr", frame_err, 1'b0);
    check("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    idle(10);

    // Short low glitch in idle: receiver wakes, rejects at mid start bit.
    busy_seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      rx_in = 1'b0;
    end
    idle(80);
    check("glitch_busy_pulsed", busy_seen, 1'b1);
    check("glitch_busy_clear", busy, 1'b0);
    check("glitch_no_valid", got_q.size(), 0);
    check("glitch_data_kept", data, 9'h000);

    // 8N1 frame at 64 clk per bit.
    send_frame(9'h0A5, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1, 1'b1);
    idle(20);
    drain("a5_8n1", 2000);

    // 9-bit, 2 stop bits; then the same with a bad second stop bit.
    send_frame(9'h1C3, 1'b1, 1'b1, 1'b1, 1'b1, -1, -1, 1'b1);
    idle(20);
    send_frame(9'h1C3, 1'b1, 1'b1, 1'b1, 1'b0, -1, -1, 1'b1);
    idle(20);
    drain("1c3_9n2", 2000);

    // Back-to-back 8N1 bytes with no idle between frames.
    send_frame(9'h000, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1, 1'b1);
    send_frame(9'h0FF, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1, 1'b1);
    send_frame(9'h05A, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1, 1'b1);
    idle(20);
    drain("b2b", 3000);

    // Reset in the middle of the data bits, then a clean frame.
    send_frame(9'h0E7, 1'b0, 1'b0, 1'b1, 1'b1, -1, 200, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_busy", busy, 1'b0);
    check("midreset_valid_cnt", got_q.size(), 0);
    rst_n = 1'b1;
    idle(20);
    check("midreset_no_late_valid", got_q.size(), 0);
    send_frame(9'h03C, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1, 1'b1);
    idle(20);
    drain("post_reset", 2000);

    // Single-clk glitch aligned to a known sample of data bit 2 (os_div=3):
    // sample s of data bit b sees the line at cycle 64*(b+1)+4+4*s.
`ifdef UART_RX_MAJORITY_EN
    send_frame(9'h0A5, 1'b0, 1'b0, 1'b1, 1'b1, 64 * 3 + 4 + 4 * 7, -1, 1'b1);
    idle(20);
    drain("maj_glitch_s7", 2000);
`else
    send_frame(9'h0A5, 1'b0, 1'b0, 1'b1, 1'b1, 64 * 3 + 4 + 4 * 8, -1, 1'b1);
    idle(20);
    drain("glitch_s8", 2000);
    // A glitch right on the single sample point must corrupt bit 2.
    send_frame(9'h0A5, 1'b0, 1'b0, 1'b1, 1'b1, 64 * 3 + 4 + 4 * 7, -1, 1'b0);
    exp_push(9'h0A1, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(20);
    drain("glitch_s7_hits", 2000);
`endif

    // Break: line low for more than a whole frame gives one zero word with
    // a framing error and no retrigger while the line stays low.
    exp_push(9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 12 * 64; c++) begin
      @(negedge clk);
      rx_in = 1'b0;
    end
    idle(40);
    drain("break", 200);

    // Enable dropped mid-frame: frame completes, next frame is ignored.
    fork
      send_frame(9'h096, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1, 1'b1);
      begin
        repeat (100) @(negedge clk);
        enable = 1'b0;
      end
    join
    idle(20);
    drain("enable_drop", 2000);
    busy_seen = 1'b0;
    send_frame(9'h033, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1, 1'b0);
    idle(20);
    check("disabled_no_busy", busy_seen, 1'b0);
    check("disabled_no_valid", got_q.size(), 0);
    enable = 1'b1;

    // Randomized frames: divider, format, payload, stop-bit errors, gaps.
    for (int k = 0; k < 12; k++) begin
      logic [8:0] w;
      bit nine;
      bit two;
      bit s1;
      bit s2;
      os_div = 16'($urandom_range(0, 3));
      w      = 9'($urandom);
      nine   = 1'($urandom);
      two    = 1'($urandom);
      s1     = ($urandom_range(0, 3) != 0);
      s2     = ($urandom_range(0, 3) != 0);
      send_frame(w, nine, two, s1, s2, -1, -1, 1'b1);
      idle($urandom_range(4, 30));
    end
    base = 0;
    drain("random", 4000 + base);

    check("valid_pulse_width", long_pulses, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
